// File: rtl/jk_bank_sequencer_pkg.sv
// Shared definitions for the JK bank sequencer: opcode values and FSM state encoding.
package jk_seq_pkg;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_CLEAR  = 3'b010;
   localparam logic [2:0] OP_SET    = 3'b011;
   localparam logic [2:0] OP_TOGGLE = 3'b100;
   localparam logic [2:0] OP_COUNT  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/jk_bank_sequencer_cell.sv
// One JK flip-flop cell of the bank; CLR overrides J/K and clears the cell.
module jk_cell (
   input  logic CK,
   input  logic CLR,
   input  logic J,
   input  logic K,
   output logic Q
);

   logic q_q;

   // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
   always_ff @(posedge CK) begin
      if (CLR) begin
         q_q <= 1'b0;
      end else begin
         case ({J, K})
            2'b01:   q_q <= 1'b0;
            2'b10:   q_q <= 1'b1;
            2'b11:   q_q <= ~q_q;
            default: q_q <= q_q;
         endcase
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer for two requesters sharing a WIDTH-cell JK bank; drives J/K per cycle.
module jk_bank_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CK,
   input  logic             CLR,
   input  logic [1:0]       req,
   input  logic [2:0]       op0,
   input  logic [WIDTH-1:0] d0,
   input  logic [2:0]       op1,
   input  logic [WIDTH-1:0] d1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] Q
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             owner_q, owner_d;
   logic             ptr_q, ptr_d;

   logic             win;
   logic [WIDTH-1:0] j_vec, k_vec;

   // Bit i toggles on an increment when every lower bit is already 1.
   function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] q);
      logic c;
      c = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         carry_mask[i] = c;
         c             = c & q[i];
      end
   endfunction

   always_comb begin
      if (req == 2'b11) win = ptr_q;
      else              win = req[1];
   end

   // gnt is the ready half of a valid/ready handshake: op/d are taken at the end of this cycle.
   assign gnt  = (state_q == ST_IDLE && req != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign done = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign busy = (state_q != ST_IDLE);

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      j_vec = '0;
      k_vec = '0;
      if (state_q == ST_EXEC) begin
         case (op_q)
            OP_LOAD:   begin j_vec = d_q;  k_vec = ~d_q; end
            OP_CLEAR:  begin j_vec = '0;   k_vec = '1;   end
            OP_SET:    begin j_vec = '1;   k_vec = '0;   end
            OP_TOGGLE: begin j_vec = d_q;  k_vec = d_q;  end
            OP_COUNT:  if (d_q != '0) begin
               j_vec = carry_mask(Q);
               k_vec = carry_mask(Q);
            end
            default:   ;
         endcase
      end else if (state_q == ST_COUNT) begin
         j_vec = carry_mask(Q);
         k_vec = carry_mask(Q);
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      d_d     = d_q;
      rem_d   = rem_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: if (req != 2'b00) begin
            owner_d = win;
            op_d    = win ? op1 : op0;
            d_d     = win ? d1 : d0;
            ptr_d   = ~win;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (op_q == OP_COUNT && d_q > WIDTH'(1)) begin
               rem_d   = d_q - WIDTH'(1);
               state_d = ST_COUNT;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_COUNT: begin
            rem_d = rem_q - WIDTH'(1);
            if (rem_q == WIDTH'(1)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CK) begin
      if (CLR) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         d_q     <= '0;
         rem_q   <= '0;
         owner_q <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         d_q     <= d_d;
         rem_q   <= rem_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .CK  (CK),
         .CLR (CLR),
         .J   (j_vec[g]),
         .K   (k_vec[g]),
         .Q   (Q[g])
      );
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer (WIDTH=4): reset, opcodes, count wrap, round-robin, late request.
module tb_jk_bank_sequencer;

   localparam int WIDTH = 4;

   logic             CK;
   logic             CLR;
   logic [1:0]       req;
   logic [2:0]       op0, op1;
   logic [WIDTH-1:0] d0, d1;
   logic [1:0]       gnt, done;
   logic             busy;
   logic [WIDTH-1:0] Q;

   int checks;
   int failures;

   jk_bank_sequencer #(.WIDTH(WIDTH)) dut (
      .CK   (CK),
      .CLR  (CLR),
      .req  (req),
      .op0  (op0),
      .d0   (d0),
      .op1  (op1),
      .d1   (d1),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .Q    (Q)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic issue(input logic [1:0] r, input logic [2:0] o0, input logic [3:0] dd0,
                        input logic [2:0] o1, input logic [3:0] dd1);
      op0 = o0; d0 = dd0; op1 = o1; d1 = dd1; req = r;
      #1;
   endtask

   // Steps from the gnt cycle until done is seen; lat = cycles from gnt to done, -1 on timeout.
   task automatic wait_done(input bit hold, output int lat);
      logic [1:0] g;
      bit found;
      g = gnt;
      lat = 0;
      found = 0;
      while (!found && lat < 40) begin
         step();
         lat++;
         if (!hold && lat == 1) req = req & ~g;
         if (done != 2'b00) found = 1;
      end
      if (!found) lat = -1;
   endtask

   task automatic test_reset();
      int lat;
      bit stray;
      CLR = 1'b1; req = 2'b00;
      step(); step();
      CLR = 1'b0;
      #1;
      checks++; if (Q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", Q); end
      checks++; if ({busy, gnt, done} !== 5'b0) begin failures++; $display("FAIL reset_outputs got busy=%b gnt=%b done=%b exp 0", busy, gnt, done); end
      issue(2'b01, 3'b001, 4'd5, 3'b000, 4'd0);
      wait_done(0, lat);
      step();
      issue(2'b01, 3'b101, 4'd8, 3'b000, 4'd0);
      step(); req = 2'b00;
      step(); step();
      checks++; if (Q !== 4'd7 || busy !== 1'b1) begin failures++; $display("FAIL midcount_q got=%0d busy=%b exp=7 busy=1", Q, busy); end
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      checks++; if (Q !== 4'd0 || busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL abort got q=%0d busy=%b done=%b exp q=0 busy=0 done=00", Q, busy, done); end
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done !== 2'b00 || busy !== 1'b0) stray = 1;
      end
      checks++; if (stray) begin failures++; $display("FAIL abort_no_done got=stray_activity exp=quiet"); end
   endtask

   task automatic test_load();
      int lat;
      issue(2'b01, 3'b001, 4'b1010, 3'b000, 4'd0);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL load_gnt got=%b exp=01", gnt); end
      wait_done(0, lat);
      checks++; if (lat !== 2 || done !== 2'b01) begin failures++; $display("FAIL load_done got lat=%0d done=%b exp lat=2 done=01", lat, done); end
      checks++; if (Q !== 4'b1010) begin failures++; $display("FAIL load_q got=%b exp=1010", Q); end
      step();
      checks++; if (done !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL load_idle got done=%b busy=%b exp 00 0", done, busy); end
   endtask

   task automatic test_toggle_clear();
      int lat;
      issue(2'b01, 3'b100, 4'b0110, 3'b000, 4'd0);
      wait_done(0, lat);
      checks++; if (Q !== 4'b1100 || lat !== 2) begin failures++; $display("FAIL toggle got q=%b lat=%0d exp q=1100 lat=2", Q, lat); end
      step();
      issue(2'b10, 3'b000, 4'd0, 3'b010, 4'b1111);
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL clear_gnt got=%b exp=10", gnt); end
      wait_done(0, lat);
      checks++; if (Q !== 4'b0000 || done !== 2'b10) begin failures++; $display("FAIL clear got q=%b done=%b exp q=0000 done=10", Q, done); end
      step();
      issue(2'b01, 3'b011, 4'b0000, 3'b000, 4'd0);
      wait_done(0, lat);
      checks++; if (Q !== 4'b1111) begin failures++; $display("FAIL set got=%b exp=1111", Q); end
      step();
      issue(2'b01, 3'b111, 4'b0000, 3'b000, 4'd0);
      wait_done(0, lat);
      checks++; if (Q !== 4'b1111 || lat !== 2 || done !== 2'b01) begin failures++; $display("FAIL nop11x got q=%b lat=%0d done=%b exp 1111 2 01", Q, lat, done); end
      step();
   endtask

   task automatic test_count_wrap();
      int lat;
      issue(2'b10, 3'b000, 4'd0, 3'b001, 4'b1110);
      wait_done(0, lat);
      step();
      issue(2'b10, 3'b000, 4'd0, 3'b101, 4'b0011);
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL count_gnt got=%b exp=10", gnt); end
      step(); req = 2'b00;
      step();
      checks++; if (Q !== 4'b1111) begin failures++; $display("FAIL count_step1 got=%b exp=1111", Q); end
      step();
      checks++; if (Q !== 4'b0000 || done !== 2'b00) begin failures++; $display("FAIL count_step2 got q=%b done=%b exp 0000 00", Q, done); end
      step();
      checks++; if (Q !== 4'b0001 || done !== 2'b10) begin failures++; $display("FAIL count_step3 got q=%b done=%b exp 0001 10", Q, done); end
      step();
      issue(2'b01, 3'b101, 4'b0000, 3'b000, 4'd0);
      wait_done(0, lat);
      checks++; if (Q !== 4'b0001 || lat !== 2) begin failures++; $display("FAIL count_zero got q=%b lat=%0d exp 0001 2", Q, lat); end
      step();
   endtask

   task automatic test_arbitration();
      int lat;
      logic [1:0] exp_g;
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      issue(2'b11, 3'b001, 4'b0011, 3'b001, 4'b1100);
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         checks++; if (gnt !== exp_g || busy !== 1'b0) begin failures++; $display("FAIL arb_gnt%0d got gnt=%b busy=%b exp gnt=%b busy=0", k, gnt, busy, exp_g); end
         wait_done(1, lat);
         checks++; if (lat !== 2 || done !== exp_g || Q !== ((exp_g == 2'b01) ? 4'b0011 : 4'b1100)) begin
            failures++; $display("FAIL arb_done%0d got lat=%0d done=%b q=%b exp lat=2 done=%b", k, lat, done, Q, exp_g);
         end
         if (k == 3) req = 2'b00;
         step();
      end
      checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL arb_quiet got gnt=%b busy=%b exp 00 0", gnt, busy); end
   endtask

   task automatic test_late_request();
      int lat;
      int n;
      bit early_gnt;
      issue(2'b01, 3'b101, 4'd3, 3'b000, 4'd0);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL late_gnt0 got=%b exp=01", gnt); end
      step(); req = 2'b00;
      step();
      issue(2'b10, 3'b101, 4'd3, 3'b001, 4'b1010);
      early_gnt = 0;
      n = 0;
      while (done === 2'b00 && n < 40) begin
         if (gnt !== 2'b00) early_gnt = 1;
         step();
         n++;
      end
      if (gnt !== 2'b00) early_gnt = 1;
      checks++; if (early_gnt) begin failures++; $display("FAIL late_held_off got=gnt_while_busy exp=no_gnt"); end
      checks++; if (done !== 2'b01 || Q !== 4'b1111) begin failures++; $display("FAIL late_done0 got done=%b q=%b exp 01 1111", done, Q); end
      step();
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL late_gnt1 got=%b exp=10", gnt); end
      wait_done(0, lat);
      checks++; if (done !== 2'b10 || Q !== 4'b1010 || lat !== 2) begin failures++; $display("FAIL late_done1 got done=%b q=%b lat=%0d exp 10 1010 2", done, Q, lat); end
      step();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      CLR = 1'b1;
      req = 2'b00;
      op0 = 3'b000; d0 = '0;
      op1 = 3'b000; d1 = '0;
      test_reset();
      test_load();
      test_toggle_clear();
      test_count_wrap();
      test_arbitration();
      test_late_request();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
